// File: rtl/seven_seg_ctrl.sv
// CPU-bus peripheral producing the 24-bit seven_seg_data word: raw hex writes (DATA)
// or binary writes converted to six BCD digits by a one-bit-per-cycle double-dabble engine (DEC).
module seven_seg_ctrl #(
  parameter logic [19:0] DEC_MAX = 20'd999999,
  parameter logic [23:0] ERR_PAT = 24'hEEEEEE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic [23:0] seven_seg_data
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_DEC    = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  logic [1:0]  state;
  logic [4:0]  bit_cnt;
  logic [19:0] bin_sr;
  logic [23:0] bcd;
  logic [23:0] bcd_adj;
  logic [19:0] dec_raw;
  logic        busy;
  logic        req;
  logic        accept;
  logic        dec_wr;
  logic        data_wr;
  logic        dec_err;
  logic [31:0] rdata_next;
  logic        wstrb_unused;

  assign busy         = (state != ST_IDLE);
  assign req          = cpu_valid && !cpu_ack;
  assign dec_wr       = cpu_write && (cpu_addr == ADDR_DEC);
  // DEC writes stall while a conversion is in flight; everything else proceeds.
  assign accept       = req && !(dec_wr && busy);
  assign data_wr      = accept && cpu_write && (cpu_addr == ADDR_DATA);
  assign dec_err      = (|cpu_wdata[31:20]) || (cpu_wdata[19:0] > DEC_MAX);
  assign wstrb_unused = cpu_wstrb[3];

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  always_comb begin
    rdata_next = '0;
    case (cpu_addr)
      ADDR_DATA:   rdata_next = {8'h00, seven_seg_data};
      ADDR_DEC:    rdata_next = {12'h000, dec_raw};
      ADDR_STATUS: rdata_next = {31'h0, busy};
      default:     rdata_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      bin_sr         <= '0;
      bcd            <= '0;
      dec_raw        <= '0;
      cpu_ack        <= 1'b0;
      cpu_rdata      <= '0;
      seven_seg_data <= '0;
    end else begin
      cpu_ack   <= accept;
      cpu_rdata <= '0;

      case (state)
        ST_CONVERT: begin
          bin_sr <= {bin_sr[18:0], 1'b0};
          bcd    <= {bcd_adj[22:0], bin_sr[19]};
          if (bit_cnt == 5'd19) begin
            bit_cnt <= '0;
            state   <= ST_LOAD;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ST_LOAD: begin
          // A DATA write landing on the load edge aborts the result.
          if (!data_wr) seven_seg_data <= bcd;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        if (!cpu_write) begin
          cpu_rdata <= rdata_next;
        end else begin
          case (cpu_addr)
            ADDR_DATA: begin
              for (int unsigned i = 0; i < 3; i++) begin
                if (cpu_wstrb[i]) seven_seg_data[8*i +: 8] <= cpu_wdata[8*i +: 8];
              end
              state   <= ST_IDLE;
              bit_cnt <= '0;
            end
            ADDR_DEC: begin
              dec_raw <= cpu_wdata[19:0];
              if (dec_err) begin
                seven_seg_data <= ERR_PAT;
              end else begin
                bin_sr  <= cpu_wdata[19:0];
                bcd     <= '0;
                bit_cnt <= '0;
                state   <= ST_CONVERT;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Randomized bench for seven_seg_ctrl against an arithmetic model of the display word.
module tb_seven_seg_ctrl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_write = 1'b0;
  logic [3:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [23:0] seven_seg_data;

  seven_seg_ctrl #(.DEC_MAX(20'd999999), .ERR_PAT(24'hEEEEEE)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .seven_seg_data(seven_seg_data)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [23:0] model_seg = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r = '0;
    int unsigned x = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic bus(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd, output int unsigned ack_at);
    int unsigned n = 0;
    cpu_valid = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd; cpu_wstrb = ws;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!cpu_ack && n < 200);
    if (!cpu_ack) check("ack_timeout", {31'h0, cpu_ack}, 32'h1);
    rd = cpu_rdata;
    ack_at = cyc;
    cpu_valid = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
  endtask

  task automatic rd_expect(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int unsigned a;
    bus(1'b0, addr, 32'h0, 4'h0, d, a);
    check(tag, d, exp);
  endtask

  task automatic data_write(input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] d;
    int unsigned a;
    bus(1'b1, 4'h0, wd, ws, d, a);
    for (int b = 0; b < 3; b++) if (ws[b]) model_seg[8*b +: 8] = wd[8*b +: 8];
    check("data_write", {8'h0, seven_seg_data}, {8'h0, model_seg});
  endtask

  // Full DEC transaction: error pattern on ack, or result exactly 21 cycles after ack.
  task automatic dec_case(input logic [31:0] wd);
    logic [31:0] d;
    int unsigned a;
    bus(1'b1, 4'h4, wd, 4'hF, d, a);
    if (wd > 32'd999999) begin
      model_seg = 24'hEEEEEE;
      check("dec_err_pat", {8'h0, seven_seg_data}, {8'h0, model_seg});
      rd_expect("dec_err_busy", 4'h8, 32'h0);
    end else begin
      rd_expect("dec_busy", 4'h8, 32'h1);
      wait_until(a + 20);
      check("dec_pre_latency", {8'h0, seven_seg_data}, {8'h0, model_seg});
      wait_until(a + 21);
      model_seg = to_bcd(wd);
      check("dec_result", {8'h0, seven_seg_data}, {8'h0, model_seg});
      rd_expect("dec_idle", 4'h8, 32'h0);
      rd_expect("dec_readback", 4'h4, wd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int unsigned a, a2;
    logic [31:0] wd;
    logic [3:0]  addr;

    repeat (3) @(posedge clock);
    #1;
    check("rst_seg", {8'h0, seven_seg_data}, 32'h0);
    check("rst_ack", {31'h0, cpu_ack}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    rd_expect("rst_status", 4'h8, 32'h0);

    bus(1'b1, 4'h0, 32'h00123ABC, 4'hF, d, a);
    model_seg = 24'h123ABC;
    check("data_full", {8'h0, seven_seg_data}, 32'h00123ABC);
    @(posedge clock); #1;
    check("ack_single", {31'h0, cpu_ack}, 32'h0);
    rd_expect("data_read", 4'h0, 32'h00123ABC);
    data_write(32'h00FF0000, 4'h4);
    check("data_byte2", {8'h0, seven_seg_data}, 32'h00FF3ABC);
    data_write(32'hAA000011, 4'h9);

    dec_case(32'd123456);
    dec_case(32'd0);
    dec_case(32'd999999);
    dec_case(32'd1000000);
    dec_case(32'h80000001);

    // Second DEC request stalls behind the running conversion.
    bus(1'b1, 4'h4, 32'd42, 4'hF, d, a);
    wait_until(a + 4);
    bus(1'b1, 4'h4, 32'd7, 4'hF, d, a2);
    check("stall_ack_cycle", a2, a + 22);
    check("stall_first", {8'h0, seven_seg_data}, 32'h00000042);
    wait_until(a2 + 20);
    check("stall_pre", {8'h0, seven_seg_data}, 32'h00000042);
    wait_until(a2 + 21);
    check("stall_second", {8'h0, seven_seg_data}, 32'h00000007);
    model_seg = 24'h000007;

    // DATA write aborts an in-flight conversion.
    bus(1'b1, 4'h4, 32'd654321, 4'hF, d, a);
    wait_until(a + 9);
    bus(1'b1, 4'h0, 32'h00ABCDEF, 4'hF, d, a2);
    model_seg = 24'hABCDEF;
    check("abort_ack_cycle", a2, a + 10);
    check("abort_seg", {8'h0, seven_seg_data}, 32'h00ABCDEF);
    rd_expect("abort_busy", 4'h8, 32'h0);
    wait_until(a + 40);
    check("abort_stays", {8'h0, seven_seg_data}, 32'h00ABCDEF);

    // Reset mid-conversion.
    bus(1'b1, 4'h4, 32'd888888, 4'hF, d, a);
    wait_until(a + 8);
    reset_n = 1'b0;
    #1;
    check("midrst_seg", {8'h0, seven_seg_data}, 32'h0);
    check("midrst_ack", {31'h0, cpu_ack}, 32'h0);
    check("midrst_rdata", cpu_rdata, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_seg = '0;
    wait_until(cyc + 25);
    check("midrst_no_update", {8'h0, seven_seg_data}, 32'h0);
    rd_expect("midrst_busy", 4'h8, 32'h0);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0: dec_case($urandom_range(0, 999999));
        1: begin
          wd = $urandom;
          if (wd <= 32'd999999) wd = wd + 32'd1000000;
          dec_case(wd);
        end
        2: begin
          data_write($urandom, 4'($urandom_range(0, 15)));
          rd_expect("rand_data_read", 4'h0, {8'h0, model_seg});
        end
        3: begin
          addr = 4'($urandom_range(9, 15));
          if ($urandom_range(0, 1) == 1) addr = 4'h8;
          bus(1'b1, addr, $urandom, 4'hF, d, a);
          check("ignored_write", {8'h0, seven_seg_data}, {8'h0, model_seg});
          rd_expect("ignored_read", addr, (addr == 4'h8) ? 32'h0 : 32'h0);
        end
        default: begin
          addr = 4'($urandom_range(1, 3));
          rd_expect("unmapped_read", addr, 32'h0);
          rd_expect("rand_seg_read", 4'h0, {8'h0, model_seg});
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
